// File: rtl/cordic_pair_scheduler.sv
// Shares one CORDIC pair stage between two requesters: round-robin issue at the stage cadence,
// credit-limited in-flight tracking with an owner-tag FIFO, and per-pair response reassembly.
module cordic_pair_scheduler #(
   parameter int unsigned CORDIC_DATA_WIDTH = 22,
   parameter int unsigned FLOAT_DATA_WIDTH  = 32,
   parameter int unsigned MAX_INFLIGHT      = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           clk_en,
   input  logic [1:0]                     req_valid,
   output logic [1:0]                     req_ready,
   input  logic [2*CORDIC_DATA_WIDTH-1:0] req_x_one,
   input  logic [2*CORDIC_DATA_WIDTH-1:0] req_x_two,
   input  logic [2*FLOAT_DATA_WIDTH-1:0]  req_one_sq,
   input  logic [2*FLOAT_DATA_WIDTH-1:0]  req_two_sq,
   output logic                           stage_start,
   output logic [CORDIC_DATA_WIDTH-1:0]   stage_x_one,
   output logic [CORDIC_DATA_WIDTH-1:0]   stage_x_two,
   output logic [FLOAT_DATA_WIDTH-1:0]    stage_one_sq,
   output logic [FLOAT_DATA_WIDTH-1:0]    stage_two_sq,
   input  logic [CORDIC_DATA_WIDTH-1:0]   stage_result,
   input  logic [FLOAT_DATA_WIDTH-1:0]    stage_squared,
   input  logic                           stage_valid,
   input  logic                           stage_cleared,
   output logic                           resp_valid,
   output logic                           resp_id,
   output logic [CORDIC_DATA_WIDTH-1:0]   resp_result_a,
   output logic [CORDIC_DATA_WIDTH-1:0]   resp_result_b,
   output logic [FLOAT_DATA_WIDTH-1:0]    resp_sq_a,
   output logic [FLOAT_DATA_WIDTH-1:0]    resp_sq_b,
   output logic                           idle,
   output logic                           err_orphan
);

   localparam int unsigned CW    = CORDIC_DATA_WIDTH;
   localparam int unsigned FW    = FLOAT_DATA_WIDTH;
   localparam int unsigned PTR_W = $clog2(MAX_INFLIGHT);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_GAP} state_t;

   state_t            state_q, state_d;
   logic              rr_q, rr_d;
   logic [CNT_W-1:0]  inflight_q, inflight_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [MAX_INFLIGHT-1:0] tag_q, tag_d;
   logic              half_q, half_d;
   logic [CW-1:0]     half_res_q, half_res_d;
   logic [FW-1:0]     half_sq_q, half_sq_d;
   logic              start_q, start_d;
   logic [CW-1:0]     sx_one_q, sx_one_d, sx_two_q, sx_two_d;
   logic [FW-1:0]     s_one_sq_q, s_one_sq_d, s_two_sq_q, s_two_sq_d;
   logic              rv_q, rv_d, rid_q, rid_d;
   logic [CW-1:0]     ra_q, ra_d, rb_q, rb_d;
   logic [FW-1:0]     rsa_q, rsa_d, rsb_q, rsb_d;
   logic              idle_q, idle_d, orphan_q, orphan_d;

   logic complete, first_elem, orphan_hit, can_grant, grant, grant_id;

   // Grant, return-path decode and next-state computation
   always_comb begin
      req_ready  = 2'b00;
      state_d    = state_q;
      rr_d       = rr_q;
      inflight_d = inflight_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      tag_d      = tag_q;
      half_d     = half_q;
      half_res_d = half_res_q;
      half_sq_d  = half_sq_q;
      sx_one_d   = sx_one_q;
      sx_two_d   = sx_two_q;
      s_one_sq_d = s_one_sq_q;
      s_two_sq_d = s_two_sq_q;
      rid_d      = rid_q;
      ra_d       = ra_q;
      rb_d       = rb_q;
      rsa_d      = rsa_q;
      rsb_d      = rsb_q;

      complete   = stage_valid & half_q;
      first_elem = stage_valid & ~half_q & (inflight_q != '0);
      orphan_hit = stage_valid & ~half_q & (inflight_q == '0);

      // A completion in this cycle frees its credit for a same-cycle grant
      can_grant  = rst & clk_en & (state_q == ST_IDLE) &
                   ((inflight_q < CNT_W'(MAX_INFLIGHT)) | complete);
      grant      = can_grant & (|req_valid);
      grant_id   = req_valid[rr_q] ? rr_q : ~rr_q;

      if (grant) begin
         req_ready[grant_id] = 1'b1;
      end

      unique case (state_q)
         ST_IDLE:  if (grant) state_d = ST_ISSUE;
         ST_ISSUE: state_d = ST_GAP;
         ST_GAP:   state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      if (grant) begin
         rr_d            = ~grant_id;
         tag_d[wr_ptr_q] = grant_id;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         sx_one_d        = grant_id ? req_x_one[2*CW-1:CW]  : req_x_one[CW-1:0];
         sx_two_d        = grant_id ? req_x_two[2*CW-1:CW]  : req_x_two[CW-1:0];
         s_one_sq_d      = grant_id ? req_one_sq[2*FW-1:FW] : req_one_sq[FW-1:0];
         s_two_sq_d      = grant_id ? req_two_sq[2*FW-1:FW] : req_two_sq[FW-1:0];
      end

      unique case ({grant, complete})
         2'b10:   inflight_d = inflight_q + CNT_W'(1);
         2'b01:   inflight_d = inflight_q - CNT_W'(1);
         default: inflight_d = inflight_q;
      endcase

      if (first_elem) begin
         half_d     = 1'b1;
         half_res_d = stage_result;
         half_sq_d  = stage_squared;
      end

      if (complete) begin
         half_d   = 1'b0;
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
         rid_d    = tag_q[rd_ptr_q];
         ra_d     = half_res_q;
         rsa_d    = half_sq_q;
         rb_d     = stage_result;
         rsb_d    = stage_squared;
      end

      start_d  = grant;
      rv_d     = complete;
      orphan_d = orphan_q | orphan_hit;
      idle_d   = (state_d == ST_IDLE) & (inflight_d == '0) & stage_cleared;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         rr_q       <= 1'b0;
         inflight_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         tag_q      <= '0;
         half_q     <= 1'b0;
         half_res_q <= '0;
         half_sq_q  <= '0;
         start_q    <= 1'b0;
         sx_one_q   <= '0;
         sx_two_q   <= '0;
         s_one_sq_q <= '0;
         s_two_sq_q <= '0;
         rv_q       <= 1'b0;
         rid_q      <= 1'b0;
         ra_q       <= '0;
         rb_q       <= '0;
         rsa_q      <= '0;
         rsb_q      <= '0;
         idle_q     <= 1'b0;
         orphan_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_q       <= rr_d;
         inflight_q <= inflight_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         tag_q      <= tag_d;
         half_q     <= half_d;
         half_res_q <= half_res_d;
         half_sq_q  <= half_sq_d;
         start_q    <= start_d;
         sx_one_q   <= sx_one_d;
         sx_two_q   <= sx_two_d;
         s_one_sq_q <= s_one_sq_d;
         s_two_sq_q <= s_two_sq_d;
         rv_q       <= rv_d;
         rid_q      <= rid_d;
         ra_q       <= ra_d;
         rb_q       <= rb_d;
         rsa_q      <= rsa_d;
         rsb_q      <= rsb_d;
         idle_q     <= idle_d;
         orphan_q   <= orphan_d;
      end
   end

   assign stage_start   = start_q;
   assign stage_x_one   = sx_one_q;
   assign stage_x_two   = sx_two_q;
   assign stage_one_sq  = s_one_sq_q;
   assign stage_two_sq  = s_two_sq_q;
   assign resp_valid    = rv_q;
   assign resp_id       = rid_q;
   assign resp_result_a = ra_q;
   assign resp_result_b = rb_q;
   assign resp_sq_a     = rsa_q;
   assign resp_sq_b     = rsb_q;
   assign idle          = idle_q;
   assign err_orphan    = orphan_q;

endmodule
